voice_wave_player: RTL
======================

// Module: voice_wave_player
// PURPOSE
//  Downstream consumer of the SDRAM voice FIFO read port. Requests one wave (WAVE_SIZE words) at a time,
//  captures returned words into a two-bank ping-pong buffer, and plays samples out one per i_sample_tick
//  toward the audio DAC. Reports underrun (tick with no full bank) and protocol errors (short/long wave).
// PARAMETERS
//  WAVE_SIZE   32  words per wave; must match the FIFO's wave size; power of two, 4..256
//  DATA_WIDTH  16  sample width
//  CLS_HOLD    8   cycles o_cls_raddr is held on flush (>= 4 so FIFO sees it while idle)
// PORTS
//  i_clk          in   1   system clock (same clock as the SDRAM FIFO)
//  i_rst_n        in   1   asynchronous active-low reset
//  o_rd           out  1   read request level to FIFO i_rd
//  o_cls_raddr    out  1   clear FIFO read address, to FIFO i_cls_raddr
//  i_rd_data      in   DW  FIFO o_rd_data
//  i_rd_ef        in   1   FIFO o_rd_ef: i_rd_data valid this cycle
//  i_rd_done      in   1   FIFO o_rd_done: one full wave delivered (single-cycle pulse)
//  i_flush        in   1   pulse: discard buffered audio, rewind FIFO read pointer
//  i_sample_tick  in   1   one-cycle strobe at the audio sample rate
//  o_sample       out  DW  current output sample
//  o_sample_vld   out  1   pulse, one cycle after i_sample_tick
//  o_underrun     out  1   pulse alongside o_sample_vld when no full bank was available
//  o_err          out  1   sticky: wave delivered with count != WAVE_SIZE; cleared by i_flush
// BEHAVIOUR
//  Reset: o_rd=0, o_cls_raddr=0, o_sample=0, o_sample_vld=0, o_underrun=0, o_err=0; both banks empty,
//    wr_bank=0, rd_bank=0, play index 0, FSM in IDLE.
//  Fill FSM (IDLE, FILL, FLUSH):
//   IDLE : if bank_full[wr_bank]==0 -> FILL, o_rd<=1, fill count<=0.
//   FILL : o_rd held high. Each i_rd_ef writes i_rd_data to bank[wr_bank][count], count++.
//          FIFO may deliver a wave in several partial bursts; hold o_rd until i_rd_done.
//          On i_rd_done: bank_full[wr_bank]<=1, wr_bank toggles, o_rd<=0, -> IDLE (o_rd low >= 1 cycle).
//          If count != WAVE_SIZE at i_rd_done -> o_err<=1 (bank still marked full).
//          i_rd_ef with count==WAVE_SIZE: word dropped, o_err<=1.
//   FLUSH: entered from any state on i_flush. o_rd=0, o_cls_raddr=1 for CLS_HOLD cycles; both banks
//          empty, play index 0, rd_bank=wr_bank=0, o_err<=0; i_rd_ef/i_rd_done ignored. Then -> IDLE.
//  Playback (independent of FSM, suspended during FLUSH):
//   i_sample_tick with bank_full[rd_bank]: next cycle o_sample=bank[rd_bank][idx], o_sample_vld=1; idx++.
//     idx wrap to 0 at WAVE_SIZE-1: bank_full[rd_bank]<=0, rd_bank toggles.
//   i_sample_tick with bank not full: o_sample_vld=1, o_underrun=1, o_sample per VOICE_HOLD_LAST_EN; idx unchanged.
//   Ticks during FLUSH: o_sample_vld=1, o_underrun=1.
//  Simultaneous: release of rd_bank and fill completion of the other bank in the same cycle both take effect;
//   FSM sees released bank next cycle. Fill never targets the bank being played (wr_bank!=rd_bank while both full).
//  Buffer read latency 1 cycle (registered RAM output feeds o_sample directly).
// CONFIGURATION
//  VOICE_HOLD_LAST_EN defined: on underrun o_sample repeats last valid sample (0 after reset/flush).
//  Not defined: on underrun o_sample=0 (silence).
// STRUCTURE
//  voice_pkg: DATA_WIDTH, WAVE_SIZE default, fill FSM state encoding (one-hot, 8-bit like other voice FSMs).
//  Sub-module voice_wave_bank: 2*WAVE_SIZE x DW simple dual-port RAM, 1 write port (fill), 1 registered read
//   port (playback), address = {bank, index}.
// TESTING
//  1 Reset, FIFO model delivers 32 words 0x0100..0x011F + i_rd_done -> bank0 full, o_rd drops, reissued for bank1.
//  2 Both banks full, 64 ticks -> o_sample 0x0100..0x013F in order, no o_underrun, banks refill.
//  3 Wave split into bursts 10+22 words with o_rd kept high -> bank holds all 32, o_err=0.
//  4 FIFO empty, tick -> o_underrun=1; o_sample=0 without macro, =last sample (e.g. 0x013F) with macro.
//  5 i_rd_done after only 20 words -> o_err=1 sticky; 33rd word on i_rd_ef -> dropped, o_err=1.
//  6 i_flush mid-FILL -> o_rd=0 next cycle, o_cls_raddr high 8 cycles, banks empty, o_err=0, refill resumes.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared constants and fill-FSM encoding for the voice wave player.
package voice_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int WAVE_SIZE  = 32;
  localparam int CLS_HOLD   = 8;

  // One-hot, 8 bits wide to match the other voice-path FSMs.
  typedef enum logic [7:0] {
    FILL_IDLE  = 8'b0000_0001,
    FILL_FILL  = 8'b0000_0010,
    FILL_FLUSH = 8'b0000_0100
  } fill_state_e;

endpackage

// File: rtl/voice_wave_bank.sv
// Ping-pong sample store: 2*WAVE_SIZE words, one write port, one registered read port.
module voice_wave_bank #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The output register only moves on a read, so it naturally holds the last played sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/voice_wave_player.sv
// Requests waves from the SDRAM voice FIFO into a ping-pong buffer and plays one sample per tick.
// Build option: VOICE_HOLD_LAST_EN repeats the last played sample on underrun instead of silence.
module voice_wave_player
  import voice_pkg::*;
#(
  parameter int WAVE_SIZE  = voice_pkg::WAVE_SIZE,
  parameter int DATA_WIDTH = voice_pkg::DATA_WIDTH,
  parameter int CLS_HOLD   = voice_pkg::CLS_HOLD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_rd,
  output logic                  o_cls_raddr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_ef,
  input  logic                  i_rd_done,
  input  logic                  i_flush,
  input  logic                  i_sample_tick,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_vld,
  output logic                  o_underrun,
  output logic                  o_err,
  output fill_state_e           o_dbg_state
);

  localparam int AW = $clog2(WAVE_SIZE);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(CLS_HOLD) + 1;
  localparam logic [CW-1:0] WS_C      = CW'(WAVE_SIZE);
  localparam logic [AW-1:0] IDX_LAST  = AW'(WAVE_SIZE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CLS_HOLD - 1);
`ifdef VOICE_HOLD_LAST_EN
  localparam bit HOLD_LAST_EN = 1'b1;
`else
  localparam bit HOLD_LAST_EN = 1'b0;
`endif

  fill_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic            rd_q, rd_d, cls_q, cls_d, err_q, err_d;
  logic            vld_q, vld_d, udr_q, udr_d, show_q, show_d, have_last_q, have_last_d;
  logic            we, re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_d        = rd_q;
    cls_d       = cls_q;
    err_d       = err_q;
    vld_d       = 1'b0;
    udr_d       = 1'b0;
    show_d      = show_q;
    have_last_d = have_last_q;
    we          = 1'b0;
    re          = 1'b0;

    case (state_q)
      FILL_IDLE: begin
        if (!full_q[wr_bank_q]) begin
          state_d = FILL_FILL;
          rd_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      FILL_FILL: begin
        if (i_rd_ef) begin
          if (cnt_q < WS_C) begin
            we    = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // A word arriving with done is counted before the length check.
        if (i_rd_done) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          rd_d              = 1'b0;
          state_d           = FILL_IDLE;
          if (cnt_d != WS_C) err_d = 1'b1;
        end
      end
      FILL_FLUSH: begin
        if (hold_q == HOLD_LAST) begin
          state_d = FILL_IDLE;
          cls_d   = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = FILL_IDLE;
    endcase

    // Fill only ever targets the bank not being played, so the two full_d updates never collide.
    if (i_sample_tick) begin
      vld_d = 1'b1;
      if (state_q == FILL_FLUSH || i_flush) begin
        udr_d  = 1'b1;
        show_d = 1'b0;
      end else if (full_q[rd_bank_q]) begin
        re          = 1'b1;
        show_d      = 1'b1;
        have_last_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d             = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        udr_d  = 1'b1;
        show_d = 1'b0;
      end
    end

    if (i_flush) begin
      state_d = FILL_FLUSH;
      hold_d  = '0;
      rd_d    = 1'b0;
      cls_d   = 1'b1;
      we      = 1'b0;
    end
    if (i_flush || state_q == FILL_FLUSH) begin
      full_d      = '0;
      idx_d       = '0;
      cnt_d       = '0;
      rd_bank_d   = 1'b0;
      wr_bank_d   = 1'b0;
      err_d       = 1'b0;
      have_last_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= FILL_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_q        <= 1'b0;
      cls_q       <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      udr_q       <= 1'b0;
      show_q      <= 1'b0;
      have_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_q        <= rd_d;
      cls_q       <= cls_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      udr_q       <= udr_d;
      show_q      <= show_d;
      have_last_q <= have_last_d;
    end
  end

  voice_wave_bank #(
    .DW(DATA_WIDTH),
    .AW(AW + 1)
  ) u_bank (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .we_i    (we),
    .waddr_i ({wr_bank_q, cnt_q[AW-1:0]}),
    .wdata_i (i_rd_data),
    .re_i    (re),
    .raddr_i ({rd_bank_q, idx_q}),
    .rdata_o (ram_rdata)
  );

  assign o_rd         = rd_q;
  assign o_cls_raddr  = cls_q;
  assign o_err        = err_q;
  assign o_sample_vld = vld_q;
  assign o_underrun   = udr_q;
  assign o_dbg_state  = state_q;
  assign o_sample     = (show_q || (HOLD_LAST_EN && have_last_q)) ? ram_rdata : '0;

endmodule
